// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  localparam int FRAME_HDR_BYTES = 2;
  localparam int BYTES_PER_WORD  = 4;
  localparam int DEPTH_DEFAULT   = 256;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte link plus instruction-memory write port.
// master = host/memory side, slave = loader.
interface imem_loader_if;

  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_waddr,
    input  mem_wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_waddr,
    output mem_wdata
  );

endinterface

// File: rtl/imem_loader_word_packer.sv
// Packs bytes MSB-first into 32-bit words. word/word_valid are combinational
// so the consumer can register the completed word on the 4th byte's edge.
module imem_loader_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [23:0] shreg;
  logic [1:0]  cnt;

  assign word       = {shreg, byte_in};
  assign word_valid = byte_en && (cnt == 2'(BYTES_PER_WORD - 1));

  // Shift in accepted bytes; the counter wraps to 0 after each full word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (byte_en) begin
      shreg <= {shreg[15:0], byte_in};
      cnt   <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte frame into instruction
// memory and holds the CPU in reset until a verified program is present.
//
// state    | meaning
// S_IDLE   | after reset, waiting for start
// S_LEN_HI | expecting length MSB
// S_LEN_LO | expecting length LSB, range-checked on arrival
// S_DATA   | receiving payload words
// S_CHECK  | expecting checksum byte
// S_DONE   | program verified, CPU released
// S_ERR    | length or checksum fault, CPU held
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.slave  link,
  output logic          cpu_rst,
  output logic          done,
  output logic          error,
  output logic [AW:0]   words_loaded
);

  state_t      state, state_nxt;
  logic        ready;
  logic        accept;
  logic        start_ok;
  logic        byte_en;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [15:0] len_rx;
  logic [7:0]  cks;
  logic        last_word;
  logic [31:0] word;
  logic        word_valid;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;

  assign accept    = link.in_valid && ready;
  assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign byte_en   = accept && (state == S_DATA);
  assign len_rx    = {len_hi, link.in_data};
  assign last_word = (16'(words_loaded) + 16'd1) == len;

  assign link.in_ready  = ready;
  assign link.mem_we    = mem_we;
  assign link.mem_waddr = mem_waddr;
  assign link.mem_wdata = mem_wdata;

  imem_loader_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .byte_en    (byte_en),
    .byte_in    (link.in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; ready depends only on the registered state.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        ready = 1'b1;
        if (accept) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        ready = 1'b1;
        if (accept) begin
          if (len_rx == 16'd0)            state_nxt = S_CHECK;
          else if (len_rx > 16'(DEPTH))   state_nxt = S_ERR;
          else                            state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        ready = 1'b1;
        if (word_valid && last_word) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        ready = 1'b1;
        if (accept) state_nxt = (link.in_data == cks) ? S_DONE : S_ERR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame length capture and running payload checksum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_hi <= '0;
      len    <= '0;
      cks    <= '0;
    end else begin
      if (accept && state == S_LEN_HI) len_hi <= link.in_data;
      if (accept && state == S_LEN_LO) len <= len_rx;
      if (start_ok)     cks <= '0;
      else if (byte_en) cks <= cks ^ link.in_data;
    end
  end

  // Registered memory write port and word counter; the counter advances
  // on the same edge that raises mem_we so both are visible together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start_ok) begin
        words_loaded <= '0;
      end else if (word_valid) begin
        mem_we       <= 1'b1;
        mem_waddr    <= {{(30 - AW){1'b0}}, words_loaded[AW-1:0], 2'b00};
        mem_wdata    <= word;
        words_loaded <= words_loaded + 1'b1;
      end
    end
  end

  // Status flags and CPU reset: released only on a verified checksum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done    <= 1'b0;
      error   <= 1'b0;
      cpu_rst <= 1'b1;
    end else if (start_ok) begin
      done    <= 1'b0;
      error   <= 1'b0;
      cpu_rst <= 1'b1;
    end else if (state != S_DONE && state_nxt == S_DONE) begin
      done    <= 1'b1;
      cpu_rst <= 1'b0;
    end else if (state != S_ERR && state_nxt == S_ERR) begin
      error   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader. Frames are built from word
// lists; expected writes and outcome come from the word list and an XOR
// over its bytes.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cpu_rst;
  logic       done;
  logic       error;
  logic [8:0] words_loaded;

  int checks   = 0;
  int failures = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] wr_wl[$];

  imem_loader_if link ();

  imem_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .link         (link),
    .cpu_rst      (cpu_rst),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // Record every memory write cycle, away from the active edge.
  always @(negedge clk) begin
    if (link.mem_we === 1'b1) begin
      wr_addr.push_back(link.mem_waddr);
      wr_data.push_back(link.mem_wdata);
      wr_wl.push_back(32'(words_loaded));
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xor_cks(input logic [31:0] w[$]);
    logic [7:0] c = 8'h00;
    foreach (w[i]) c ^= w[i][31:24] ^ w[i][23:16] ^ w[i][15:8] ^ w[i][7:0];
    return c;
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present bytes one at a time with random idle gaps; a byte is taken on
  // the edge where in_valid and in_ready are both high.
  task automatic send_bytes(input logic [7:0] b[$], input int gap_pct);
    int budget;
    foreach (b[i]) begin
      if (gap_pct > 0)
        while ($urandom_range(99) < gap_pct) begin
          link.in_valid = 1'b0;
          @(posedge clk); #1;
        end
      link.in_valid = 1'b1;
      link.in_data  = b[i];
      budget = 50;
      while (!link.in_ready && budget > 0) begin
        @(posedge clk); #1;
        budget--;
      end
      if (budget == 0) begin
        check("in_ready_timeout", 32'(link.in_ready), 32'd1);
        link.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    link.in_valid = 1'b0;
  endtask

  task automatic load_frame(input logic [31:0] w[$], input logic [7:0] cks, input int gap_pct);
    logic [7:0] f[$];
    logic [15:0] n;
    n = 16'(w.size());
    f.push_back(n[15:8]);
    f.push_back(n[7:0]);
    foreach (w[i]) for (int k = 3; k >= 0; k--) f.push_back(w[i][8*k +: 8]);
    f.push_back(cks);
    send_bytes(f, gap_pct);
  endtask

  task automatic check_load(input string tag, input logic [31:0] w[$], input logic [7:0] cks);
    bit ok;
    ok = (cks == xor_cks(w));
    check({tag, "_writes"}, 32'(wr_addr.size()), 32'(w.size()));
    for (int i = 0; i < w.size() && i < wr_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_addr[i], 32'(i * 4));
      check($sformatf("%s_data%0d", tag, i), wr_data[i], w[i]);
      check($sformatf("%s_wl%0d", tag, i), wr_wl[i], 32'(i + 1));
    end
    check({tag, "_done"}, 32'(done), 32'(ok));
    check({tag, "_error"}, 32'(error), 32'(!ok));
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(!ok));
    check({tag, "_words_loaded"}, 32'(words_loaded), 32'(w.size()));
    check({tag, "_in_ready"}, 32'(link.in_ready), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 32'(link.in_ready), 32'd0);
    check({tag, "_mem_we"}, 32'(link.mem_we), 32'd0);
    check({tag, "_mem_waddr"}, link.mem_waddr, 32'd0);
    check({tag, "_mem_wdata"}, link.mem_wdata, 32'd0);
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    logic [31:0] w[$];
    logic [7:0]  f[$];

    rst = 1'b1;
    start = 1'b0;
    link.in_valid = 1'b0;
    link.in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Two-word program with correct checksum.
    w = {32'h20080005, 32'h00000000};
    wr_addr.delete(); wr_data.delete(); wr_wl.delete();
    do_start();
    load_frame(w, 8'h2D, 0);
    check_load("n2_good", w, 8'h2D);

    // Restart from DONE: CPU goes back into reset, status clears.
    do_start();
    check("restart_cpu_rst", 32'(cpu_rst), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    check("restart_in_ready", 32'(link.in_ready), 32'd1);

    // Same program, corrupted checksum.
    wr_addr.delete(); wr_data.delete(); wr_wl.delete();
    load_frame(w, 8'h2C, 0);
    check_load("n2_bad", w, 8'h2C);

    // Length above memory depth aborts right after the length bytes.
    wr_addr.delete(); wr_data.delete(); wr_wl.delete();
    do_start();
    f = {8'h01, 8'h01};
    send_bytes(f, 0);
    check("n257_error", 32'(error), 32'd1);
    check("n257_done", 32'(done), 32'd0);
    check("n257_in_ready", 32'(link.in_ready), 32'd0);
    check("n257_cpu_rst", 32'(cpu_rst), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("n257_writes", 32'(wr_addr.size()), 32'd0);

    // Empty program.
    w.delete();
    wr_addr.delete(); wr_data.delete(); wr_wl.delete();
    do_start();
    load_frame(w, 8'h00, 0);
    check_load("n0", w, 8'h00);

    // Full memory with random data and host stalls.
    w.delete();
    for (int i = 0; i < 256; i++) w.push_back($urandom);
    wr_addr.delete(); wr_data.delete(); wr_wl.delete();
    do_start();
    load_frame(w, xor_cks(w), 30);
    check_load("n256", w, xor_cks(w));
    if (wr_addr.size() > 0)
      check("n256_last_addr", wr_addr[wr_addr.size() - 1], 32'h3FC);

    // Reset in the middle of a load, after 6 payload bytes.
    wr_addr.delete(); wr_data.delete(); wr_wl.delete();
    do_start();
    f = {8'h00, 8'h03};
    for (int i = 0; i < 6; i++) f.push_back(8'($urandom));
    send_bytes(f, 20);
    check("midload_words_loaded", 32'(words_loaded), 32'd1);
    do_start();
    check("midload_start_ignored_wl", 32'(words_loaded), 32'd1);
    check("midload_start_ignored_ready", 32'(link.in_ready), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_vals("midload_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("after_rst_in_ready", 32'(link.in_ready), 32'd0);

    // A fresh complete load after the reset.
    w.delete();
    for (int i = 0; i < 5; i++) w.push_back($urandom);
    wr_addr.delete(); wr_data.delete(); wr_wl.delete();
    do_start();
    load_frame(w, xor_cks(w), 25);
    check_load("post_rst", w, xor_cks(w));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Write-side counterpart to the processor's instruction memory: accepts a byte stream from a host link over a valid/ready handshake, packs it into 32-bit instruction words, and writes them to consecutive word addresses of the instruction memory. Holds the CPU core in reset until a complete, checksum-verified program has been written. Sits between the host link and the instruction memory write port, alongside the program counter's reset input.

## Interface
- DEPTH, 256, instruction memory size in words; max loadable program length
- AW, 8, word-index width, clog2(DEPTH)
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse: begin a load; ignored unless in IDLE, DONE or ERR
- in_valid  in  1  host byte valid
- in_data  in  8  host byte
- in_ready  out  1  loader can accept a byte this cycle
- mem_we  out  1  instruction memory write strobe, one cycle per word
- mem_waddr  out  32  byte address of the word being written (word-aligned, index<<2, matches PC addressing)
- mem_wdata  out  32  instruction word
- cpu_rst  out  1  reset to the CPU core (PC, pipeline registers)
- done  out  1  load completed and checksum matched
- error  out  1  load aborted (length or checksum fault)
- words_loaded  out  AW+1  words written in current/last load

## Operation
- Frame: LEN_HI, LEN_LO (N, 16-bit big-endian), then N words of 4 bytes each, MSB first, then one checksum byte = XOR of all 4N payload bytes.
- Byte accepted on a rising edge with in_valid && in_ready.
- States: IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERR.
- IDLE/DONE/ERR --start--> LEN_HI; clears done, error, words_loaded, checksum, byte counter; cpu_rst = 1.
- LEN_HI --byte--> LEN_LO. LEN_LO --byte--> N==0: CHECK; N>DEPTH: ERR; else DATA.
- DATA: shift byte into word register; checksum ^= byte; after 4th byte issue write at index words_loaded, then increment; after word N go to CHECK.
- CHECK --byte--> byte==checksum: DONE (done=1, cpu_rst=0); else ERR (error=1, cpu_rst stays 1).
- in_ready = 1 in LEN_HI, LEN_LO, DATA, CHECK; 0 otherwise (bytes in other states are not consumed).
- start while in LEN_HI..CHECK: ignored.
- Arithmetic: word index is AW bits, never wraps because N ≤ DEPTH is enforced; mem_waddr = {zero-pad, index, 2'b00}.

## Timing
- Reset values: in_ready 0, mem_we 0, mem_waddr 0, mem_wdata 0, cpu_rst 1, done 0, error 0, words_loaded 0, state IDLE.
- Throughput: one byte per cycle; in_ready has no combinational dependence on in_valid.
- mem_we, mem_waddr, mem_wdata registered: valid in the cycle after the 4th byte of a word is accepted; mem_we high exactly one cycle.
- words_loaded increments in the same cycle mem_we is high.
- done/error asserted the cycle after the checksum byte is accepted; held until next start or rst.
- cpu_rst deasserts together with done; reasserts the cycle after an accepted start.
- Reset mid-load: immediate return to IDLE; already written memory words are not cleared; cpu_rst stays 1.
- Host stalls (in_valid low) at any point: state and partial word held indefinitely.

## Structure
- Shared package: state enum, FRAME_HDR_BYTES = 2, BYTES_PER_WORD = 4, default DEPTH.
- One sub-module: word_packer (byte shift register + 2-bit byte counter, emits word_valid pulse); FSM, checksum, address counter and cpu_rst in the top.

## Test plan
- Load N=2: 00 02, 20 08 00 05, 00 00 00 00, cks 0x2D -> writes 0x20080005 @0x0, 0x00000000 @0x4; done=1, cpu_rst=0, words_loaded=2.
- Bad checksum (same frame, cks 0x2C) -> both words written, error=1, done=0, cpu_rst=1.
- N=0x0101 (257 > DEPTH) -> ERR right after LEN_LO, no mem_we, in_ready=0.
- N=0: 00 00, cks 00 -> done=1, no mem_we.
- in_valid toggled randomly mid-word, N=256 full memory -> last write at 0x3FC, words_loaded=256, data matches.
- rst pulse after 6 data bytes -> IDLE, cpu_rst=1, outputs at reset values; subsequent start + full frame completes normally.
